// File: rtl/draw_sweep_arbiter.sv
// Round-robin sweep sequencer for the draw framebuffer's dual-port memory.
// Each write emits one pair: port A gets {pair,0} and port B gets {pair,1}.
module draw_sweep_arbiter #(
  parameter int PAIR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [PAIR_W-1:0] base0,
  input  logic [PAIR_W-1:0] cnt0,
  input  logic [PAIR_W-1:0] base1,
  input  logic [PAIR_W-1:0] cnt1,
  input  logic              stall,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [1:0]        done,
  output logic              we,
  output logic [PAIR_W:0]   Q_a,
  output logic [PAIR_W:0]   Q_b,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a client holds req high until its one-cycle done pulse; requests
  // are only looked at in IDLE, and base/cnt are captured on the grant cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PAIR_W-1:0]   r_pair;
  logic [PAIR_W-1:0]   r_remaining;
  logic [1:0]          r_gnt;
  logic                r_last;
  logic                w_grant;
  logic                w_pick;
  logic                w_we;
  logic [PAIR_W-1:0]   w_base_sel;
  logic [PAIR_W-1:0]   w_cnt_sel;

  assign w_base_sel = w_pick ? base1 : base0;
  assign w_cnt_sel  = w_pick ? cnt1  : cnt0;

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_pick  = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_grant = 1'b1;
          // On a tie the client that was not served last wins.
          w_pick  = (req == 2'b11) ? ~r_last : req[1];
          w_next  = (w_cnt_sel != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_we = ~stall;
        if (w_we && (r_remaining == PAIR_W'(1))) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pair      <= '0;
      r_remaining <= '0;
      r_gnt       <= 2'b00;
      r_last      <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_pair      <= w_base_sel;
        r_remaining <= w_cnt_sel;
        r_gnt       <= w_pick ? 2'b10 : 2'b01;
        r_last      <= w_pick;
      end else if (w_we) begin
        r_pair      <= r_pair + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      if (r_state == S_DONE) begin
        r_gnt <= 2'b00;
      end
    end
  end

  assign gnt         = r_gnt;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign we          = w_we;
  assign Q_a         = {r_pair, 1'b0};
  assign Q_b         = {r_pair, 1'b1};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_draw_sweep_arbiter.sv
// Directed self-checking bench for draw_sweep_arbiter with hand-computed expectations.
module tb_draw_sweep_arbiter;

  localparam int PAIR_W = 13;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [PAIR_W-1:0] base0;
  logic [PAIR_W-1:0] cnt0;
  logic [PAIR_W-1:0] base1;
  logic [PAIR_W-1:0] cnt1;
  logic              stall;
  logic [1:0]        gnt;
  logic              busy;
  logic [1:0]        done;
  logic              we;
  logic [PAIR_W:0]   Q_a;
  logic [PAIR_W:0]   Q_b;
  logic [1:0]        o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  draw_sweep_arbiter #(.PAIR_W(PAIR_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .base0(base0), .cnt0(cnt0), .base1(base1), .cnt1(cnt1),
    .stall(stall), .gnt(gnt), .busy(busy), .done(done), .we(we),
    .Q_a(Q_a), .Q_b(Q_b), .o_dbg_state(o_dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d required %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks: drive just after the rising edge, sample on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sample();
  endtask

  // Checks n consecutive writes from start pair; the first write is one edge away.
  task automatic expect_writes(input string tag, input logic [1:0] gnt_e,
                               input logic [PAIR_W-1:0] start, input int n);
    logic [PAIR_W-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      tick();
      sample();
      check({tag, "_we"}, we, 1);
      check({tag, "_qa"}, Q_a, {p, 1'b0});
      check({tag, "_qb"}, Q_b, {p, 1'b1});
      check({tag, "_gnt"}, gnt, gnt_e);
      p = p + 1'b1;
    end
  endtask

  task automatic expect_done(input string tag, input logic [1:0] gnt_e);
    tick();
    sample();
    check({tag, "_done"}, done, gnt_e);
    check({tag, "_dgnt"}, gnt, gnt_e);
    check({tag, "_dwe"}, we, 0);
    check({tag, "_dbusy"}, busy, 1);
  endtask

  task automatic expect_idle(input string tag);
    tick();
    sample();
    check({tag, "_ibusy"}, busy, 0);
    check({tag, "_ignt"}, gnt, 0);
    check({tag, "_idone"}, done, 0);
  endtask

  // invariants sampled every falling edge
  always @(negedge clk) begin
    if (!reset) begin
      check("inv_qb", Q_b, Q_a | 14'd1);
      check("inv_gnt1hot", $onehot0(gnt), 1);
      if (we) check("inv_we_run", o_dbg_state, 1);
      if (done != 2'b00) check("inv_done_state", o_dbg_state, 2);
    end
  end

  logic stall_pat [6];
  logic [13:0] qa_pat [6];
  logic we_pat [6];

  initial begin
    reset = 1'b1; req = 2'b00; stall = 1'b0;
    base0 = '0; cnt0 = '0; base1 = '0; cnt1 = '0;

    // reset state
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", we, 0);
    check("rst_qa", Q_a, 0);
    check("rst_qb", Q_b, 1);
    check("rst_state", o_dbg_state, 0);

    // legacy sweep: 640 x 128
    base0 = 13'd640; cnt0 = 13'd128; req = 2'b01;
    expect_writes("leg", 2'b01, 13'd640, 128);
    expect_done("leg", 2'b01);
    req = 2'b00;
    expect_idle("leg");

    // tie from reset: client 0 first, then client 1, then client 0 again
    do_reset();
    base0 = 13'd0; cnt0 = 13'd4; base1 = 13'd100; cnt1 = 13'd2; req = 2'b11;
    expect_writes("tie0", 2'b01, 13'd0, 4);
    expect_done("tie0", 2'b01);
    req = 2'b10;
    expect_idle("tie0");
    expect_writes("tie1", 2'b10, 13'd100, 2);
    expect_done("tie1", 2'b10);
    req = 2'b11;
    expect_idle("tie1");
    expect_writes("tie2", 2'b01, 13'd0, 1);

    // stall: client 1 base 10 cnt 3, stall on RUN cycles 2..4
    do_reset();
    stall_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    we_pat    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    qa_pat    = '{14'd20, 14'd22, 14'd22, 14'd22, 14'd22, 14'd24};
    base1 = 13'd10; cnt1 = 13'd3; req = 2'b10;
    for (int c = 0; c < 6; c++) begin
      tick();
      stall = stall_pat[c];
      sample();
      check("stl_we", we, we_pat[c]);
      check("stl_qa", Q_a, qa_pat[c]);
      check("stl_gnt", gnt, 2'b10);
    end
    tick();
    stall = 1'b0;
    sample();
    check("stl_done", done, 2'b10);
    req = 2'b00;
    expect_idle("stl");

    // zero-length sweep, then wrap through pair 0
    do_reset();
    base0 = 13'd5; cnt0 = 13'd0; req = 2'b01;
    expect_done("zero", 2'b01);
    req = 2'b00;
    expect_idle("zero");
    check("zero_we", we, 0);
    base0 = 13'd8190; cnt0 = 13'd4; req = 2'b01;
    tick(); sample(); check("wrap_qa0", Q_a, 16380);
    tick(); sample(); check("wrap_qa1", Q_a, 16382);
    tick(); sample(); check("wrap_qa2", Q_a, 0);
    check("wrap_qb2", Q_b, 1);
    tick(); sample(); check("wrap_qa3", Q_a, 2);
    check("wrap_we3", we, 1);
    expect_done("wrap", 2'b01);
    req = 2'b00;
    expect_idle("wrap");

    // reset on the 5th write of a 128-pair sweep
    base0 = 13'd640; cnt0 = 13'd128; req = 2'b01;
    expect_writes("mrst", 2'b01, 13'd640, 4);
    tick();
    reset = 1'b1;
    sample();
    check("mrst_we5", we, 1);
    check("mrst_qa5", Q_a, 1288);
    tick();
    base0 = 13'd50; cnt0 = 13'd2;
    sample();
    check("mrst_we", we, 0);
    check("mrst_gnt", gnt, 0);
    check("mrst_qa", Q_a, 0);
    check("mrst_qb", Q_b, 1);
    check("mrst_done", done, 0);
    check("mrst_busy", busy, 0);
    reset = 1'b0;
    expect_writes("mrst_new", 2'b01, 13'd50, 2);
    expect_done("mrst_new", 2'b01);
    req = 2'b00;
    expect_idle("mrst_new");

    // request drop mid-sweep with client 1 pending
    do_reset();
    base0 = 13'd20; cnt0 = 13'd3; base1 = 13'd7; cnt1 = 13'd1; req = 2'b11;
    expect_writes("drop0a", 2'b01, 13'd20, 1);
    req = 2'b10;
    expect_writes("drop0b", 2'b01, 13'd21, 2);
    expect_done("drop0", 2'b01);
    expect_idle("drop0");
    expect_writes("drop1", 2'b10, 13'd7, 1);
    expect_done("drop1", 2'b10);
    req = 2'b00;
    expect_idle("drop1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
